// File: rtl/mmio_input_port.sv
// mmio_input_port
//   Memory-mapped input FIFO on the PicoRV32 native memory bus. A producer
//   pushes 32-bit words over a valid/ready stream. Firmware pops them by
//   reading DATA_ADDR and polls STATUS_ADDR for count/empty/full/underflow.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   synchronous, active-low reset
//   in_valid   in   producer word valid
//   in_ready   out  FIFO can accept a word (= !full)
//   in_data    in   producer word
//   mem_valid  in   CPU request
//   mem_addr   in   CPU address (full 32-bit compare)
//   mem_wdata  in   CPU write data (not used)
//   mem_wstrb  in   nonzero = write
//   mem_ready  out  one-cycle acknowledge
//   mem_rdata  out  read data, valid while mem_ready=1, otherwise 0
//   sel        out  combinational address decode for the system read mux
//   underflow  out  sticky flag: DATA read while the FIFO was empty
module mmio_input_port #(
  parameter int          DEPTH       = 8,
  parameter int          ADDR_W      = 3,
  parameter logic [31:0] DATA_ADDR   = 32'h1000_0010,
  parameter logic [31:0] STATUS_ADDR = 32'h1000_0014
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        sel,
  output logic        underflow
);

  localparam logic [1:0]      S_IDLE   = 2'd0;
  localparam logic [1:0]      S_ACK    = 2'd1;
  localparam logic [1:0]      S_GAP    = 2'd2;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic [31:0]       fifo_mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [31:0]       rdata_p1;
  logic [31:0]       rd_mux;
  logic [31:0]       status_word;

  logic full, empty, push, pop;
  logic hit_data, hit_status, is_write, accept;
  logic uf_set, uf_clr;
  logic unused_wdata;

  assign unused_wdata = ^mem_wdata;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;

  // A push is blocked while full even if a pop happens in the same cycle.
  assign push = in_valid && !full;

  assign hit_data   = (mem_addr == DATA_ADDR);
  assign hit_status = (mem_addr == STATUS_ADDR);
  assign sel        = mem_valid && (hit_data || hit_status);
  assign is_write   = |mem_wstrb;
  assign accept     = (state == S_IDLE) && sel;

  assign pop    = accept && !is_write && hit_data && !empty;
  assign uf_set = accept && !is_write && hit_data && empty;
  assign uf_clr = accept && is_write && hit_status && mem_wstrb[3];

  assign status_word = {7'b0, underflow, 6'b0, full, empty,
                        {(16 - ADDR_W - 1){1'b0}}, count};

  // Read value captured at accept; uses pre-push state, so a word pushed in
  // the accept cycle is not seen by that read.
  always_comb begin
    rd_mux = '0;
    if (!is_write) begin
      if (hit_data && !empty) begin
        rd_mux = fifo_mem[rd_ptr];
      end else if (hit_status) begin
        rd_mux = status_word;
      end
    end
  end

  // Control state: FSM, pointers, occupancy, sticky flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (sel) state <= S_ACK;
        S_ACK:   state <= S_GAP;
        default: state <= S_IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
      // Setting event has priority over a clear.
      if (uf_set) begin
        underflow <= 1'b1;
      end else if (uf_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  // Data storage: no reset, output is gated by mem_ready instead.
  always_ff @(posedge clk) begin
    if (push)   fifo_mem[wr_ptr] <= in_data;
    if (accept) rdata_p1 <= rd_mux;
  end

  // ---- stage p1: acknowledge cycle ----
  assign mem_ready = (state == S_ACK);
  assign mem_rdata = mem_ready ? rdata_p1 : 32'h0;

endmodule
